// File: rtl/rank_pkg.sv
// rank_pkg: rank op codes and a saturating add shared by the rank engine files
package rank_pkg;
  localparam int STRICT_OP = 0;
  localparam int RR_OP = 1;
  localparam int WRR_OP = 2;
  localparam int NUM_RANK_OPS = 3;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction
endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: show-ahead FIFO (clk, rst, din/wr_en in, rd_en pop, dout head, empty, nearly_full at DEPTH-1)
module fallthrough_small_fifo #(
  parameter int WIDTH = 8,
  parameter int L2_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);
  localparam int DEPTH = 2**L2_DEPTH;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [L2_DEPTH-1:0] rd_ptr, wr_ptr;
  logic [L2_DEPTH:0] cnt;
  logic wr, rd;
  assign rd = rd_en && !empty;
  assign wr = wr_en && !cnt[L2_DEPTH];
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      rd_ptr <= rd_ptr + L2_DEPTH'(rd);
      wr_ptr <= wr_ptr + L2_DEPTH'(wr);
      cnt <= cnt + (L2_DEPTH+1)'(wr) - (L2_DEPTH+1)'(rd);
    end
  assign dout = mem[rd_ptr];
  assign empty = cnt == '0;
  assign nearly_full = cnt >= (L2_DEPTH+1)'(DEPTH-1);
endmodule

// File: rtl/flow_rank_table.sv
// flow_rank_table: per-flow last-rank registers (clk, rst_n, flush clears all, we/idx/wdata write, rdata = comb read of idx)
module flow_rank_table #(
  parameter int L2_NUM_FLOWS = 2,
  parameter int RANK_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    we,
  input  logic [L2_NUM_FLOWS-1:0] idx,
  input  logic [RANK_WIDTH-1:0]   wdata,
  output logic [RANK_WIDTH-1:0]   rdata
);
  logic [RANK_WIDTH-1:0] tbl [2**L2_NUM_FLOWS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tbl <= '{default: '0};
    else if (flush) tbl <= '{default: '0};
    else if (we) tbl[idx] <= wdata;
  assign rdata = tbl[idx];
endmodule

// File: rtl/rank_engine.sv
// rank_engine: descriptor in (insert/meta/op/flowID/weight, busy), base_wr/base_in, flush; rank out (valid_out/remove/rank_out/meta_out), err_cnt
module rank_engine
  import rank_pkg::*;
#(
  parameter int FLOW_ID_WIDTH = 16,
  parameter int FLOW_WEIGHT_WIDTH = 8,
  parameter int L2_NUM_FLOWS = 2,
  parameter int RANK_CODE_BITS = 2,
  parameter int RANK_WIDTH = 16,
  parameter int META_WIDTH = 16,
  parameter int L2_FIFO_DEPTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         busy,
  input  logic                         insert,
  input  logic [META_WIDTH-1:0]        meta_in,
  input  logic [RANK_CODE_BITS-1:0]    rank_op_in,
  input  logic [FLOW_ID_WIDTH-1:0]     flowID_in,
  input  logic [FLOW_WEIGHT_WIDTH-1:0] flow_weight_in,
  input  logic                         base_wr,
  input  logic [RANK_WIDTH-1:0]        base_in,
  input  logic                         flush,
  input  logic                         remove,
  output logic                         valid_out,
  output logic [RANK_WIDTH-1:0]        rank_out,
  output logic [META_WIDTH-1:0]        meta_out,
  output logic [15:0]                  err_cnt
);
  localparam int MAX_NUM_FLOWS = 2**L2_NUM_FLOWS;
  localparam int IN_W = RANK_CODE_BITS + META_WIDTH + FLOW_ID_WIDTH + FLOW_WEIGHT_WIDTH;
  localparam logic [RANK_WIDTH-1:0] RANK_MAX = '1;
  logic bad_op, in_empty, out_empty, out_nf, pop, is_rr, is_wrr, oor;
  logic [RANK_CODE_BITS-1:0] op_fix, h_op;
  logic [META_WIDTH-1:0] h_meta;
  logic [FLOW_ID_WIDTH-1:0] h_flow;
  logic [FLOW_WEIGHT_WIDTH-1:0] h_wt, cost;
  logic [L2_NUM_FLOWS-1:0] idx;
  logic [RANK_WIDTH-1:0] base, rr_rd, wrr_rd, rr_start, wrr_start, rr_rank, wrr_rank, rank;
  logic [RANK_WIDTH+META_WIDTH-1:0] out_head;
  logic [1:0] err_inc;
  logic [16:0] err_sum;
  assign bad_op = 32'(rank_op_in) >= NUM_RANK_OPS;
  assign op_fix = bad_op ? RANK_CODE_BITS'(STRICT_OP) : rank_op_in;
  fallthrough_small_fifo #(.WIDTH(IN_W), .L2_DEPTH(L2_FIFO_DEPTH)) in_fifo (
    .clk(clk), .rst(~rst_n), .din({op_fix, meta_in, flowID_in, flow_weight_in}), .wr_en(insert),
    .rd_en(pop), .dout({h_op, h_meta, h_flow, h_wt}), .empty(in_empty), .nearly_full(busy)
  );
  assign pop = !in_empty && !out_nf;
  assign is_rr = h_op == RANK_CODE_BITS'(RR_OP);
  assign is_wrr = h_op == RANK_CODE_BITS'(WRR_OP);
  assign oor = h_flow >= FLOW_ID_WIDTH'(MAX_NUM_FLOWS);
  assign idx = h_flow[L2_NUM_FLOWS-1:0];
  assign cost = (h_wt == '0) ? FLOW_WEIGHT_WIDTH'(1) : h_wt;
  flow_rank_table #(.L2_NUM_FLOWS(L2_NUM_FLOWS), .RANK_WIDTH(RANK_WIDTH)) rr_tbl (
    .clk(clk), .rst_n(rst_n), .flush(flush), .we(pop && is_rr && !oor), .idx(idx), .wdata(rr_rank), .rdata(rr_rd)
  );
  flow_rank_table #(.L2_NUM_FLOWS(L2_NUM_FLOWS), .RANK_WIDTH(RANK_WIDTH)) wrr_tbl (
    .clk(clk), .rst_n(rst_n), .flush(flush), .we(pop && is_wrr && !oor), .idx(idx), .wdata(wrr_rank), .rdata(wrr_rd)
  );
  always_comb begin
    rr_start = (rr_rd > base) ? rr_rd : base;
    wrr_start = (wrr_rd > base) ? wrr_rd : base;
    rr_rank = RANK_WIDTH'(sat_add(32'(rr_start), 32'd1, 32'(RANK_MAX)));
    wrr_rank = RANK_WIDTH'(sat_add(32'(wrr_start), 32'(cost), 32'(RANK_MAX)));
    rank = ((is_rr || is_wrr) && oor) ? RANK_MAX : is_rr ? rr_rank : is_wrr ? wrr_rank : RANK_WIDTH'(h_flow);
  end
  fallthrough_small_fifo #(.WIDTH(RANK_WIDTH+META_WIDTH), .L2_DEPTH(L2_FIFO_DEPTH)) out_fifo (
    .clk(clk), .rst(~rst_n), .din({rank, h_meta}), .wr_en(pop), .rd_en(remove),
    .dout(out_head), .empty(out_empty), .nearly_full(out_nf)
  );
  assign valid_out = !out_empty;
  assign {rank_out, meta_out} = valid_out ? out_head : '0;
  assign err_inc = {1'b0, insert && bad_op} + {1'b0, pop && (is_rr || is_wrr) && oor};
  assign err_sum = {1'b0, err_cnt} + 17'(err_inc);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      err_cnt <= '0;
    end else begin
      base <= flush ? '0 : base_wr ? base_in : base;
      err_cnt <= err_sum[16] ? '1 : err_sum[15:0];
    end
endmodule

// File: doc/rank_engine.md
# rank_engine

Parametrised successor rank-computation stage sitting between the packet classifier and the PIFO. It buffers descriptors and computes a rank per descriptor using one of three ops: STRICT, RR and WRR. RR and WRR keep per-flow state and take a virtual-time base fed back from the PIFO dequeue side. Ranks are delivered in arrival order through an output FIFO with valid/remove flow control.

## Interface
Parameters:
- FLOW_ID_WIDTH, 16, flow identifier width
- FLOW_WEIGHT_WIDTH, 8, per-packet WRR cost width
- L2_NUM_FLOWS, 2, log2 of per-flow table entries; MAX_NUM_FLOWS = 2**L2_NUM_FLOWS
- RANK_CODE_BITS, 2, rank-op code width
- RANK_WIDTH, 16, rank width
- META_WIDTH, 16, opaque metadata width
- L2_FIFO_DEPTH, 6, log2 depth of the input and output FIFOs

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- busy  out  1  input FIFO nearly full; insert is illegal while high
- insert  in  1  push one descriptor
- meta_in  in  META_WIDTH  metadata
- rank_op_in  in  RANK_CODE_BITS  op code: 0 STRICT, 1 RR, 2 WRR, other values invalid
- flowID_in  in  FLOW_ID_WIDTH  flow id
- flow_weight_in  in  FLOW_WEIGHT_WIDTH  WRR cost per packet
- base_wr  in  1  load the virtual-time base
- base_in  in  RANK_WIDTH  rank of the last packet dequeued by the PIFO
- flush  in  1  synchronous clear of the flow tables and the base; FIFOs are untouched
- remove  in  1  pop the output head; legal only when valid_out=1
- valid_out  out  1  output FIFO non-empty
- rank_out  out  RANK_WIDTH  head rank
- meta_out  out  META_WIDTH  head metadata
- err_cnt  out  16  count of descriptors with an invalid op or an out-of-range flow; saturates

## Operation
- Input FIFO stores {op, meta, flowID, weight}.
- Invalid op codes are rewritten to STRICT on entry and increment err_cnt.
- Compute stage pops the head when the input FIFO is non-empty and the output FIFO is not nearly full. At most one descriptor is popped per cycle.
- Table index: idx = flowID[L2_NUM_FLOWS-1:0]. If flowID >= MAX_NUM_FLOWS for an RR/WRR op, the descriptor gets rank all-ones, err_cnt increments, and the tables are not written.
- Rank rules, with all sums saturating at 2**RANK_WIDTH-1 (no wrap):
  - STRICT: rank = flowID zero-extended or truncated to RANK_WIDTH. No state change.
  - RR: start = max(last_rr[idx], base); rank = start+1; last_rr[idx] <= rank.
  - WRR: cost = max(weight,1); start = max(last_wrr[idx], base); rank = start+cost; last_wrr[idx] <= rank.
- Read-modify-write of a table completes in the pop cycle. Back-to-back descriptors of the same flow therefore see the updated value; there is no hazard stall.
- base_wr in the same cycle as a compute: the compute uses the old base; the new base takes effect next cycle.
- flush in the same cycle as a compute: flush wins. The table write is discarded, but the computed rank is still emitted.
- rank_out/meta_out are taken from the head of the output FIFO.

## Timing
- Reset values: busy=0, valid_out=0, rank_out=0, meta_out=0, err_cnt=0. Tables, base and both FIFOs are cleared.
- Reset asserted mid-operation discards all in-flight descriptors immediately.
- Latency on an empty pipe:
  - insert at cycle t.
  - Head visible and computed at t+1, written to the output FIFO at t+1.
  - valid_out=1 at t+2.
- Throughput: 1 descriptor/cycle sustained when remove is held high.
- Backpressure: with the output FIFO nearly full, the compute stage stalls and the input FIFO fills; busy rises when the input FIFO is nearly full.
- remove while valid_out=0 is ignored.
- insert while busy=1 is a protocol violation; the bench flags it.

## Structure
- Shared package rank_pkg holds: op codes STRICT_OP=0, RR_OP=1, WRR_OP=2, NUM_RANK_OPS=3, and a saturating-add function.
- Both FIFOs reuse fallthrough_small_fifo, with its reset tied to ~rst_n.
- One new sub-module, flow_rank_table:
  - per-flow register array of MAX_NUM_FLOWS × RANK_WIDTH;
  - combinational read, synchronous write, flush input;
  - instantiated twice (RR, WRR).

## Test plan
- STRICT flowIDs 5, 2, 9 inserted back-to-back -> ranks 5, 2, 9 in order; first valid_out 2 cycles after the first insert.
- RR, flow 1 ×3 then flow 2 ×1, base=0 -> ranks 1, 2, 3, 1.
- WRR, flow 0 weight 4 ×2 and flow 3 weight 0 ×1; then base_wr with base_in=20, then flow 0 weight 4 -> ranks 4, 8, 1, then 24.
- Saturation: RR flow 0 with last_rr=0xFFFF -> rank 0xFFFF, table stays 0xFFFF.
- Invalid op 3 with flowID 7, plus RR flowID 8 (MAX_NUM_FLOWS=4) -> ranks 7 and 0xFFFF, err_cnt=2.
- Hold remove=0 until busy=1; then release -> no loss, exact arrival order preserved.
- Assert rst_n low mid-stream -> valid_out=0 and busy=0 immediately; next RR flow 1 gets rank 1.
